// File: rtl/spgd_ctrl_update_if.sv
// Stream bundle for the SPGD control-update stage: products in from the
// multiplier, updated control values out to the actuator/DAC stage.
interface spgd_ctrl_update_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_BITS    = 3
) ();
    logic                  prod_valid;
    logic [DATA_WIDTH-1:0] prod_data;
    logic                  prod_ready;

    logic                  u_valid;
    logic [CH_BITS-1:0]    u_ch;
    logic [DATA_WIDTH-1:0] u_data;
    logic                  u_ready;

    // master: the update stage itself (sinks products, sources control values)
    modport master (
        input  prod_valid, prod_data, u_ready,
        output prod_ready, u_valid, u_ch, u_data
    );

    // slave: the surrounding datapath (multiplier upstream, DAC stage downstream)
    modport slave (
        output prod_valid, prod_data, u_ready,
        input  prod_ready, u_valid, u_ch, u_data
    );
endinterface

// File: rtl/spgd_ctrl_update.sv
// SPGD control-vector update: u[k] <- clamp(u[k] + product) per channel,
// streaming each updated value out and keeping the vector between passes.
module spgd_ctrl_update #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    INT_WIDTH  = 16,
    parameter int                    NUM_CH     = 8,
    parameter int                    CH_BITS    = 3,
    parameter logic [DATA_WIDTH-1:0] U_MAX      = 32'h0010_0000,
    parameter logic [DATA_WIDTH-1:0] U_MIN      = 32'hFFF0_0000,
    parameter logic [DATA_WIDTH-1:0] U_INIT     = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                clear,
    spgd_ctrl_update_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                sat_flag
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Bad parameter sets are rejected at elaboration rather than misbehaving silently.
    if (NUM_CH < 2 || CH_BITS < IDX_W || INT_WIDTH > DATA_WIDTH ||
        $signed(U_MIN) > $signed(U_MAX)) begin : g_param_err
        $error("spgd_ctrl_update: illegal parameter set");
    end

    // Clamp limits widened by one bit so they compare against the unwrapped sum.
    localparam logic signed [DATA_WIDTH:0] MAX_W = {U_MAX[DATA_WIDTH-1], U_MAX};
    localparam logic signed [DATA_WIDTH:0] MIN_W = {U_MIN[DATA_WIDTH-1], U_MIN};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                state_q;
    logic [CH_BITS-1:0]    k_q;
    logic [DATA_WIDTH-1:0] u_q [NUM_CH];
    logic                  prod_ready_q;
    logic                  u_valid_q;
    logic [DATA_WIDTH-1:0] u_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  sat_q;

    logic [IDX_W-1:0]             k_idx;
    logic [DATA_WIDTH-1:0]        cur_u;
    logic signed [DATA_WIDTH:0]   sum_w;
    logic [DATA_WIDTH-1:0]        clamped_d;
    logic                         clip_d;
    logic                         last_ch;

    assign k_idx   = k_q[IDX_W-1:0];
    assign last_ch = (k_q == CH_BITS'(NUM_CH - 1));

    // NOTE: combinational blocks use blocking assignments and give every output
    // a default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        cur_u     = u_q[k_idx];
        sum_w     = $signed({cur_u[DATA_WIDTH-1], cur_u})
                  + $signed({bus.prod_data[DATA_WIDTH-1], bus.prod_data});
        clamped_d = sum_w[DATA_WIDTH-1:0];
        clip_d    = 1'b0;
        if (sum_w > MAX_W) begin
            clamped_d = U_MAX;
            clip_d    = 1'b1;
        end else if (sum_w < MIN_W) begin
            clamped_d = U_MIN;
            clip_d    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            prod_ready_q <= 1'b0;
            u_valid_q    <= 1'b0;
            u_data_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
            // NOTE: the register file is small and must come up at U_INIT, so it
            // lives in flops with a reset rather than in an un-resettable RAM.
            for (int i = 0; i < NUM_CH; i++) begin
                u_q[i] <= U_INIT;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            u_q[i] <= U_INIT;
                        end
                    end else if (start) begin
                        k_q          <= '0;
                        sat_q        <= 1'b0;
                        prod_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ACCEPT;
                    end
                end

                ACCEPT: begin
                    if (bus.prod_valid) begin
                        u_q[k_idx]   <= clamped_d;
                        u_data_q     <= clamped_d;
                        prod_ready_q <= 1'b0;
                        u_valid_q    <= 1'b1;
                        state_q      <= EMIT;
                        if (clip_d) begin
                            sat_q <= 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (bus.u_ready) begin
                        u_valid_q <= 1'b0;
                        if (last_ch) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            k_q          <= k_q + CH_BITS'(1);
                            prod_ready_q <= 1'b1;
                            state_q      <= ACCEPT;
                        end
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.u_valid    = u_valid_q;
    assign bus.u_ch       = k_q;
    assign bus.u_data     = u_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign sat_flag       = sat_q;

endmodule
